// File: rtl/pc_unit_ras.sv
// Program-counter unit for the single-cycle MIPS core, with exception/EPC capture
// and a small circular return-address stack that predicts `jr $ra` targets.
module pc_unit_ras #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic [31:0]      instruction_i,
  input  logic             branch_i,
  input  logic             branch_ne_i,
  input  logic             zero_i,
  input  logic             jump_i,
  input  logic             jump_link_i,
  input  logic             jump_reg_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] reg_target_i,
  input  logic             exception_i,
  input  logic             eret_i,
  output logic [WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0] link_addr_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             ras_empty_o,
  output logic             ras_full_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  localparam logic [WIDTH-1:0] ResetAddr = WIDTH'(RESET_ADDR);
  localparam logic [WIDTH-1:0] ExcVector = WIDTH'(EXC_VECTOR);
  localparam logic [CntW-1:0]  CntMax    = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc4, btarget, jtarget, ras_top;
  logic [PtrW-1:0]  top_idx;
  logic             taken, push, ras_empty, ras_full;
  logic             unused_instr;

  assign unused_instr = ^instruction_i[31:26];

  assign pc4     = addr_q + WIDTH'(4);
  assign btarget = pc4 + {{(WIDTH-18){instruction_i[15]}}, instruction_i[15:0], 2'b00};
  assign jtarget = {pc4[WIDTH-1:28], instruction_i[25:0], 2'b00};
  assign taken   = branch_i & (zero_i ^ branch_ne_i);

  // ptr_q addresses the next free slot, so the top lives one entry below it.
  assign top_idx   = ptr_q - PtrW'(1);
  assign ras_top   = ras_q[top_idx];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntMax);

  always_comb begin
    addr_d = addr_q;
    epc_d  = epc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
    if (exception_i) begin
      epc_d  = addr_q;
      addr_d = ExcVector;
    end else if (!stall_i) begin
      if (eret_i) begin
        addr_d = epc_q;
      end else if (ret_i) begin
        if (!ras_empty) begin
          addr_d = ras_top;
          ptr_d  = top_idx;
          cnt_d  = cnt_q - CntW'(1);
        end else begin
          addr_d = reg_target_i;
        end
      end else if (jump_reg_i) begin
        addr_d = reg_target_i;
      end else if (jump_i) begin
        addr_d = jtarget;
        push   = jump_link_i;
      end else if (taken) begin
        addr_d = btarget;
      end else begin
        addr_d = pc4;
      end
    end
    if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      // When full the oldest entry is overwritten and the count saturates.
      cnt_d = ras_full ? cnt_q : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q <= ResetAddr;
      epc_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      addr_q <= addr_d;
      epc_q  <= epc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      if (push) begin
        ras_q[ptr_q] <= pc4;
      end
    end
  end

  assign addr_o      = addr_q;
  assign link_addr_o = pc4;
  assign epc_o       = epc_q;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed self-checking bench for pc_unit_ras: a 32-bit instance covering every
// next-PC source and the RAS, plus a 48-bit instance for wide jump/vector handling.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        reset, stall, branch, branch_ne, zero, jump, jump_link, jump_reg, ret;
  logic        exception, eret;
  logic [31:0] instr, reg_target;
  logic [31:0] addr, link_addr, epc;
  logic        ras_empty, ras_full;

  logic        w_reset, w_jump, w_jump_reg, w_exception;
  logic [31:0] w_instr;
  logic [47:0] w_reg_target, w_addr, w_link_addr, w_epc;
  logic        w_empty, w_full;
  logic        lo = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit_ras u_dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .stall_i      (stall),
    .instruction_i(instr),
    .branch_i     (branch),
    .branch_ne_i  (branch_ne),
    .zero_i       (zero),
    .jump_i       (jump),
    .jump_link_i  (jump_link),
    .jump_reg_i   (jump_reg),
    .ret_i        (ret),
    .reg_target_i (reg_target),
    .exception_i  (exception),
    .eret_i       (eret),
    .addr_o       (addr),
    .link_addr_o  (link_addr),
    .epc_o        (epc),
    .ras_empty_o  (ras_empty),
    .ras_full_o   (ras_full)
  );

  pc_unit_ras #(.WIDTH(48)) u_dut48 (
    .clk_i        (clk),
    .reset_i      (w_reset),
    .stall_i      (lo),
    .instruction_i(w_instr),
    .branch_i     (lo),
    .branch_ne_i  (lo),
    .zero_i       (lo),
    .jump_i       (w_jump),
    .jump_link_i  (lo),
    .jump_reg_i   (w_jump_reg),
    .ret_i        (lo),
    .reg_target_i (w_reg_target),
    .exception_i  (w_exception),
    .eret_i       (lo),
    .addr_o       (w_addr),
    .link_addr_o  (w_link_addr),
    .epc_o        (w_epc),
    .ras_empty_o  (w_empty),
    .ras_full_o   (w_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    stall = 0; branch = 0; branch_ne = 0; zero = 0; jump = 0; jump_link = 0;
    jump_reg = 0; ret = 0; exception = 0; eret = 0; instr = '0; reg_target = 32'h999;
  endtask

  task automatic go_to(input logic [31:0] a);
    clear();
    jump_reg = 1; reg_target = a;
    step();
    clear();
  endtask

  task automatic jal_at(input logic [31:0] a);
    go_to(a);
    jump = 1; jump_link = 1; instr = 32'h0C00_0040;
    step();
    clear();
  endtask

  initial begin
    clear();
    reset = 1; w_reset = 1;
    w_jump = 0; w_jump_reg = 0; w_exception = 0; w_instr = '0; w_reg_target = '0;
    step(); step();
    check("reset_addr", 64'(addr), 64'h0);
    check("reset_epc", 64'(epc), 64'h0);
    check("reset_empty", 64'(ras_empty), 64'h1);
    check("reset_full", 64'(ras_full), 64'h0);
    reset = 0;
    step(); check("seq_4", 64'(addr), 64'h4);
    step(); check("seq_8", 64'(addr), 64'h8);
    step(); check("seq_c", 64'(addr), 64'hC);
    check("link_addr", 64'(link_addr), 64'h10);

    // Asynchronous reset mid-run.
    go_to(32'h8);
    check("goto_8", 64'(addr), 64'h8);
    reset = 1; #1;
    check("async_reset", 64'(addr), 64'h0);
    step(); reset = 0;

    // Conditional branches, imm 0xFFFE = -8 bytes from pc4.
    go_to(32'h10);
    branch = 1; zero = 1; instr = 32'h0000_FFFE; step();
    check("beq_taken", 64'(addr), 64'hC);
    go_to(32'h10);
    branch = 1; zero = 0; instr = 32'h0000_FFFE; step();
    check("beq_not_taken", 64'(addr), 64'h14);
    go_to(32'h10);
    branch = 1; branch_ne = 1; zero = 0; instr = 32'h0000_FFFE; step();
    check("bne_taken", 64'(addr), 64'hC);
    go_to(32'h10);
    branch = 1; branch_ne = 1; zero = 1; instr = 32'h0000_FFFE; step();
    check("bne_not_taken", 64'(addr), 64'h14);

    // jal / ret round trip.
    go_to(32'h0040_0020);
    jump = 1; jump_link = 1; instr = 32'h0C10_0040; step(); clear();
    check("jal_target", 64'(addr), 64'h0040_0100);
    check("jal_not_empty", 64'(ras_empty), 64'h0);
    ret = 1; step(); clear();
    check("ret_pop", 64'(addr), 64'h0040_0024);
    check("ret_empty", 64'(ras_empty), 64'h1);
    ret = 1; reg_target = 32'h1234; step(); clear();
    check("ret_fallback", 64'(addr), 64'h1234);

    // Ret wins over jal and must not push.
    ret = 1; jump = 1; jump_link = 1; reg_target = 32'h2000; step(); clear();
    check("ret_over_jal", 64'(addr), 64'h2000);
    check("ret_over_jal_empty", 64'(ras_empty), 64'h1);

    // jump_link alone is ignored.
    go_to(32'h300);
    jump_link = 1; step(); clear();
    check("link_only_addr", 64'(addr), 64'h304);
    check("link_only_empty", 64'(ras_empty), 64'h1);

    // Overflow: five pushes into four entries, newest four come back.
    for (int i = 1; i <= 5; i++) begin
      jal_at(32'(i) << 8);
      if (i == 3) check("ras_not_full_3", 64'(ras_full), 64'h0);
      if (i == 4) check("ras_full_4", 64'(ras_full), 64'h1);
    end
    check("ras_full_5", 64'(ras_full), 64'h1);
    for (int i = 5; i >= 2; i--) begin
      ret = 1; step(); clear();
      check($sformatf("ras_pop_%0d", i), 64'(addr), 64'((32'(i) << 8) + 32'h4));
      check($sformatf("ras_nfull_%0d", i), 64'(ras_full), 64'h0);
    end
    check("ras_drained", 64'(ras_empty), 64'h1);
    ret = 1; reg_target = 32'hABC; step(); clear();
    check("ras_fifth_ret", 64'(addr), 64'hABC);

    // Stall, exception overriding stall, nested exception, eret.
    jal_at(32'h500);
    go_to(32'h40);
    stall = 1; jump = 1; jump_link = 1; instr = 32'h0C00_0100; step();
    check("stall_addr", 64'(addr), 64'h40);
    clear(); ret = 1; stall = 1; step(); clear();
    check("stall_ras", 64'(ras_empty), 64'h0);
    stall = 1; exception = 1; step(); clear();
    check("exc_addr", 64'(addr), 64'h8000_0180);
    check("exc_epc", 64'(epc), 64'h40);
    eret = 1; step(); clear();
    check("eret_addr", 64'(addr), 64'h40);
    exception = 1; step(); step(); clear();
    check("nested_epc", 64'(epc), 64'h8000_0180);
    eret = 1; step(); clear();
    check("nested_eret", 64'(addr), 64'h8000_0180);
    ret = 1; step(); clear();
    check("ras_survived", 64'(addr), 64'h504);

    // Wrap at the top of the address space.
    go_to(32'hFFFF_FFFC);
    check("wrap_link", 64'(link_addr), 64'h0);
    step();
    check("wrap_addr", 64'(addr), 64'h0);

    // 48-bit instance.
    w_reset = 0;
    #1;
    check("w48_reset", 64'(w_addr), 64'h0);
    w_jump_reg = 1; w_reg_target = 48'h1234_5678_9000; step(); w_jump_reg = 0;
    check("w48_goto", 64'(w_addr), 64'h1234_5678_9000);
    w_jump = 1; w_instr = 32'h0810_0040; step(); w_jump = 0;
    check("w48_jump", 64'(w_addr), 64'h1234_5040_0100);
    w_exception = 1; step(); w_exception = 0;
    check("w48_vector", 64'(w_addr), 64'h0000_8000_0180);
    check("w48_epc", 64'(w_epc), 64'h1234_5040_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised next-generation program-counter unit for the single-cycle MIPS core.
- Holds the PC register and selects the next PC from: sequential, conditional branch (beq/bne), jump, jal, jump-register, return, exception vector and eret.
- Adds stall, exception/EPC capture and a small circular return-address stack (RAS) that predicts `jr $ra` targets.
- Feeds instruction memory through `addr` and the register file through `link_addr`.

Parameters:
- WIDTH, 32: PC/address width; must be at least 32.
- RESET_ADDR, 32'h00000000 (zero-extended to WIDTH): PC value during and after reset.
- EXC_VECTOR, 32'h80000180 (zero-extended to WIDTH): PC loaded on exception.
- RAS_DEPTH, 4: number of RAS entries; must be a power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and all state this cycle
- instruction  in  32  current instruction; [25:0] jump index, [15:0] branch immediate
- branch  in  1  conditional branch instruction
- branch_ne  in  1  0 = beq (taken when zero=1), 1 = bne (taken when zero=0)
- zero  in  1  ALU zero flag
- jump  in  1  j/jal
- jump_link  in  1  jal qualifier: push return address
- jump_reg  in  1  jr/jalr, target = reg_target
- ret  in  1  jr $ra, target = RAS top
- reg_target  in  WIDTH  register-file rs value
- exception  in  1  trap request
- eret  in  1  return from exception
- addr  out  WIDTH  current PC (registered)
- link_addr  out  WIDTH  addr+4 (combinational)
- epc  out  WIDTH  exception PC (registered)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (async, any time, including mid-stall or mid-operation): addr=RESET_ADDR, epc=0, all RAS entries=0, RAS count=0, top pointer=0. ras_empty=1, ras_full=0.
- Arithmetic: all adds are modulo 2^WIDTH; wrap at all-ones is silent.
  - pc4 = addr+4.
  - btarget = pc4 + (sign-extended instruction[15:0] shifted left 2).
  - jtarget = {pc4[WIDTH-1:28], instruction[25:0], 2'b00}.
- taken = branch & (zero XOR branch_ne).
- Next-PC priority, highest first; only the winning action's side effects occur:
  1. exception: epc<=addr; addr<=EXC_VECTOR. Overrides stall.
  2. stall: addr, epc and RAS all hold.
  3. eret: addr<=epc.
  4. ret: if RAS non-empty, addr<=RAS top, then pop (count-1, pointer-1). If empty, addr<=reg_target and RAS is unchanged.
  5. jump_reg: addr<=reg_target.
  6. jump: addr<=jtarget. If jump_link is also set, push pc4.
  7. taken: addr<=btarget.
  8. Otherwise: addr<=pc4.
- Push: pointer+1 (mod RAS_DEPTH), entry[pointer]<=pc4, count+1 saturating at RAS_DEPTH. When full, the oldest entry is overwritten (circular) and count stays at RAS_DEPTH.
- jump_link without jump: ignored.
- ret together with jump: ret wins and no push occurs.
- Latency: every update lands on the next rising clk edge.
- link_addr tracks addr combinationally with zero latency.
- Inputs are sampled only on clk edges; there are no handshakes.
- Nested exceptions: the second exception overwrites epc with the then-current addr (the vector address).

Test Plan:
- Reset, then 3 idle cycles → addr 0x0, 0x4, 0x8, 0xC. Assert reset mid-run at addr 0x8 → addr 0x0 immediately, before the next clock edge.
- At addr 0x10: beq with imm 0xFFFE, zero=1 → next addr 0x0C. Same with zero=0 → 0x14. bne with zero=0 → 0x0C.
- At addr 0x00400020: jal index 0x0100040 → addr 0x00400100, RAS count 1. Then ret → addr 0x00400024, ras_empty=1. Ret on empty with reg_target 0x1234 → addr 0x1234.
- Five jal pushes with RAS_DEPTH=4 → ras_full=1. Then four rets return the four most recent return addresses, newest first. A fifth ret falls back to reg_target.
- At addr 0x40 with stall=1 and jump=1 → addr stays 0x40 and RAS is unchanged. stall=1 with exception → addr 0x80000180, epc 0x40. Then eret → addr 0x40.
- addr 0xFFFFFFFC, sequential → addr wraps to 0x0. WIDTH=48 instance: jump keeps pc4[47:28].
